// File: rtl/rle_yuv_decoder_pkg.sv
// Shared constants for the run-length YUV decoder: FSM state encoding and
// the field positions of a compressed source word.
package rle_yuv_decoder_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EMIT   = 3'd3,
      DONE   = 3'd4,
      ERROR  = 3'd5
   } state_t;

   localparam int RUN_MSB = 15;
   localparam int RUN_LSB = 8;
   localparam int VAL_MSB = 7;
   localparam int VAL_LSB = 0;

endpackage

// File: rtl/rle_decoder_controller.sv
// Control FSM for the RLE decoder: sequences fetch/decode/emit and issues
// datapath load/increment strobes plus the memory strobes.
module rle_decoder_controller
   import rle_yuv_decoder_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic src_at_end,
   input  logic dst_at_end,
   input  logic word_is_end,
   input  logic run_is_one,
   input  logic wr_ready,
   output logic rd_en,
   output logic wr_en,
   output logic done,
   output logic clr,
   output logic ld_word,
   output logic inc_src,
   output logic inc_dst,
   output logic dec_run,
   output logic set_err
);

   state_t state_reg, state_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      done       = 1'b0;
      clr        = 1'b0;
      ld_word    = 1'b0;
      inc_src    = 1'b0;
      inc_dst    = 1'b0;
      dec_run    = 1'b0;
      set_err    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               clr        = 1'b1;
               state_next = FETCH;
            end
         end
         FETCH: begin
            if (src_at_end) begin
               set_err    = 1'b1;
               state_next = ERROR;
            end else begin
               rd_en      = 1'b1;
               inc_src    = 1'b1;
               state_next = DECODE;
            end
         end
         DECODE: begin
            ld_word    = 1'b1;
            state_next = word_is_end ? DONE : EMIT;
         end
         EMIT: begin
            // Buffer overflow is checked before the write is offered.
            if (dst_at_end) begin
               set_err    = 1'b1;
               state_next = ERROR;
            end else begin
               wr_en = 1'b1;
               if (wr_ready) begin
                  inc_dst = 1'b1;
                  dec_run = 1'b1;
                  if (run_is_one) begin
                     state_next = FETCH;
                  end
               end
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         ERROR: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/rle_yuv_decoder.sv
// Expands run-length words (run count, byte value) from source memory into
// raw YUV bytes; pulses done (with err on overrun) when finished.
module rle_yuv_decoder
   import rle_yuv_decoder_pkg::*;
#(
   parameter int unsigned       ADDR_W  = 16,
   parameter logic [ADDR_W-1:0] SRC_LEN = {ADDR_W{1'b1}},
   parameter logic [ADDR_W-1:0] DST_LEN = {ADDR_W{1'b1}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [15:0]       rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic              wr_ready,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] out_count
);

   logic [ADDR_W-1:0] src_ptr_reg;
   logic [ADDR_W-1:0] dst_ptr_reg;
   logic [ADDR_W-1:0] out_count_reg;
   logic [7:0]        run_reg;
   logic [7:0]        value_reg;
   logic              err_reg;

   logic clr, ld_word, inc_src, inc_dst, dec_run, set_err;

   rle_decoder_controller u_ctrl (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .src_at_end  (src_ptr_reg == SRC_LEN),
      .dst_at_end  (dst_ptr_reg == DST_LEN),
      .word_is_end (rd_data[RUN_MSB:RUN_LSB] == 8'd0),
      .run_is_one  (run_reg == 8'd1),
      .wr_ready    (wr_ready),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .done        (done),
      .clr         (clr),
      .ld_word     (ld_word),
      .inc_src     (inc_src),
      .inc_dst     (inc_dst),
      .dec_run     (dec_run),
      .set_err     (set_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         src_ptr_reg   <= '0;
         dst_ptr_reg   <= '0;
         out_count_reg <= '0;
         run_reg       <= '0;
         value_reg     <= '0;
         err_reg       <= 1'b0;
      end else begin
         if (clr) begin
            src_ptr_reg   <= '0;
            dst_ptr_reg   <= '0;
            out_count_reg <= '0;
            err_reg       <= 1'b0;
         end
         if (inc_src) begin
            src_ptr_reg <= src_ptr_reg + 1'b1;
         end
         if (ld_word) begin
            run_reg   <= rd_data[RUN_MSB:RUN_LSB];
            value_reg <= rd_data[VAL_MSB:VAL_LSB];
         end
         if (inc_dst) begin
            dst_ptr_reg   <= dst_ptr_reg + 1'b1;
            out_count_reg <= out_count_reg + 1'b1;
         end
         if (dec_run) begin
            run_reg <= run_reg - 1'b1;
         end
         if (set_err) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign rd_addr   = src_ptr_reg;
   assign wr_addr   = dst_ptr_reg;
   assign wr_data   = value_reg;
   assign err       = err_reg;
   assign out_count = out_count_reg;

endmodule

// File: tb/tb_rle_yuv_decoder.sv
// Bench for rle_yuv_decoder: three instances (default bounds, DST_LEN=4,
// SRC_LEN=2) checked against a stream-level expansion model.
module tb_rle_yuv_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_ready = 1'b1;
   logic        start_v     [3];
   logic        rd_en_w     [3];
   logic [15:0] rd_addr_w   [3];
   logic [15:0] rd_data_w   [3];
   logic        wr_en_w     [3];
   logic [15:0] wr_addr_w   [3];
   logic [7:0]  wr_data_w   [3];
   logic        done_w      [3];
   logic        err_w       [3];
   logic [15:0] out_count_w [3];

   logic [15:0] mem [256];
   logic [15:0] stream [$];
   int          exp_addr [$];
   int          exp_data [$];
   logic        exp_err;
   int          exp_cyc;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam logic [15:0] SLP = (gi == 2) ? 16'd2 : 16'hFFFF;
         localparam logic [15:0] DLP = (gi == 1) ? 16'd4 : 16'hFFFF;
         rle_yuv_decoder #(.ADDR_W(16), .SRC_LEN(SLP), .DST_LEN(DLP)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start_v[gi]),
            .rd_en     (rd_en_w[gi]),
            .rd_addr   (rd_addr_w[gi]),
            .rd_data   (rd_data_w[gi]),
            .wr_en     (wr_en_w[gi]),
            .wr_addr   (wr_addr_w[gi]),
            .wr_data   (wr_data_w[gi]),
            .wr_ready  (wr_ready),
            .done      (done_w[gi]),
            .err       (err_w[gi]),
            .out_count (out_count_w[gi])
         );
         always @(posedge clk) rd_data_w[gi] <= mem[rd_addr_w[gi][7:0]];
      end
   endgenerate

   function automatic int src_len(input int inst);
      return (inst == 2) ? 2 : 65535;
   endfunction

   function automatic int dst_len(input int inst);
      return (inst == 1) ? 4 : 65535;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic load_stream();
      for (int i = 0; i < 256; i++) mem[i] = 16'h01EE;
      foreach (stream[i]) mem[i] = stream[i];
   endtask

   // Expands the loaded stream directly from the word format and bounds.
   task automatic model(input int inst);
      int   dst, cyc, run;
      logic stop;
      exp_addr.delete();
      exp_data.delete();
      exp_err = 1'b0;
      dst = 0;
      cyc = 0;
      stop = 1'b0;
      for (int i = 0; !stop; i++) begin
         if (i == src_len(inst)) begin
            cyc++;
            exp_err = 1'b1;
            stop = 1'b1;
         end else begin
            cyc += 2;
            run = int'(mem[i][15:8]);
            if (run == 0) stop = 1'b1;
            for (int j = 0; j < run && !stop; j++) begin
               if (dst == dst_len(inst)) begin
                  cyc++;
                  exp_err = 1'b1;
                  stop = 1'b1;
               end else begin
                  exp_addr.push_back(dst);
                  exp_data.push_back(int'(mem[i][7:0]));
                  dst++;
                  cyc++;
               end
            end
         end
      end
      exp_cyc = cyc + 1;
   endtask

   // mode 0: wr_ready high; 1: random; 2: four-cycle stall after first write
   task automatic run_dec(input int inst, input int mode, input string name);
      int          got_addr [$];
      int          got_data [$];
      int          cyc, first_wr, stall_cnt, n;
      logic        seen_done, stall_p;
      logic [15:0] s_addr;
      logic [7:0]  s_data;
      model(inst);
      @(negedge clk);
      start_v[inst] = 1'b1;
      @(negedge clk);
      start_v[inst] = 1'b0;
      cyc = 1; first_wr = 0; stall_cnt = 0;
      seen_done = 1'b0; stall_p = 1'b0;
      while (!seen_done && cyc < 3000) begin
         if (stall_p) begin
            chk({name, "_stall_en"}, 32'(wr_en_w[inst]), 32'd1);
            chk({name, "_stall_addr"}, 32'(wr_addr_w[inst]), 32'(s_addr));
            chk({name, "_stall_data"}, 32'(wr_data_w[inst]), 32'(s_data));
            stall_p = 1'b0;
         end
         chk({name, "_rd_bound"},
             32'(rd_en_w[inst] && (int'(rd_addr_w[inst]) == src_len(inst))), 32'd0);
         if (wr_en_w[inst] && first_wr == 0) first_wr = cyc;
         case (mode)
            1: wr_ready = 1'($urandom_range(0, 1));
            2: wr_ready = !(wr_en_w[inst] && got_addr.size() == 1 && stall_cnt < 4);
            default: wr_ready = 1'b1;
         endcase
         if (mode == 2 && !wr_ready) stall_cnt++;
         if (wr_en_w[inst] && wr_ready) begin
            got_addr.push_back(int'(wr_addr_w[inst]));
            got_data.push_back(int'(wr_data_w[inst]));
         end
         if (wr_en_w[inst] && !wr_ready) begin
            stall_p = 1'b1;
            s_addr = wr_addr_w[inst];
            s_data = wr_data_w[inst];
         end
         if (done_w[inst]) begin
            seen_done = 1'b1;
            chk({name, "_err"}, 32'(err_w[inst]), 32'(exp_err));
            chk({name, "_count"}, 32'(out_count_w[inst]), 32'(exp_addr.size()));
            if (mode == 0) chk({name, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
         end
         @(negedge clk);
         cyc++;
      end
      wr_ready = 1'b1;
      chk({name, "_timeout"}, 32'(seen_done), 32'd1);
      chk({name, "_done_pulse"}, 32'(done_w[inst]), 32'd0);
      chk({name, "_err_held"}, 32'(err_w[inst]), 32'(exp_err));
      chk({name, "_count_held"}, 32'(out_count_w[inst]), 32'(exp_addr.size()));
      chk({name, "_nwrites"}, 32'(got_addr.size()), 32'(exp_addr.size()));
      if (exp_addr.size() > 0) chk({name, "_first_wr"}, 32'(first_wr), 32'd3);
      if (mode == 2) chk({name, "_stalls"}, 32'(stall_cnt), 32'd4);
      n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
      for (int i = 0; i < n; i++) begin
         chk({name, "_addr"}, 32'(got_addr[i]), 32'(exp_addr[i]));
         chk({name, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
      end
      $display("txn %s inst=%0d mode=%0d writes=%0d err=%0b cycles=%0d",
               name, inst, mode, got_addr.size(), err_w[inst], cyc);
   endtask

   initial begin
      int nw;
      for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_rd_en", 32'(rd_en_w[i]), 32'd0);
         chk("rst_wr_en", 32'(wr_en_w[i]), 32'd0);
         chk("rst_done", 32'(done_w[i]), 32'd0);
         chk("rst_err", 32'(err_w[i]), 32'd0);
         chk("rst_count", 32'(out_count_w[i]), 32'd0);
         chk("rst_wr_addr", 32'(wr_addr_w[i]), 32'd0);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;

      stream = '{16'h0341, 16'h0000};
      load_stream();
      run_dec(0, 0, "basic");

      stream = '{16'h0210, 16'h0120, 16'h0000};
      load_stream();
      run_dec(0, 0, "two_runs");
      run_dec(0, 2, "stall");

      stream = '{16'h0577, 16'h0000};
      load_stream();
      run_dec(1, 0, "dst_over");

      stream = '{16'h0101, 16'h0102};
      load_stream();
      run_dec(2, 0, "src_over");

      stream = '{16'hFF33, 16'h0000};
      load_stream();
      run_dec(0, 0, "run255");

      // Abandon a long run mid-emit, then decode again from scratch.
      stream = '{16'hFF55, 16'h0000};
      load_stream();
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (12) @(negedge clk);
      chk("pre_rst_wr_en", 32'(wr_en_w[0]), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_wr_en", 32'(wr_en_w[0]), 32'd0);
      chk("mid_rst_wr_addr", 32'(wr_addr_w[0]), 32'd0);
      chk("mid_rst_wr_data", 32'(wr_data_w[0]), 32'd0);
      chk("mid_rst_rd_en", 32'(rd_en_w[0]), 32'd0);
      chk("mid_rst_done", 32'(done_w[0]), 32'd0);
      chk("mid_rst_count", 32'(out_count_w[0]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      $display("txn mid_emit_reset inst=0 applied");
      run_dec(0, 1, "after_rst");

      for (int t = 0; t < 8; t++) begin
         stream.delete();
         nw = $urandom_range(1, 4);
         for (int w = 0; w < nw; w++)
            stream.push_back({8'($urandom_range(1, 12)), 8'($urandom_range(0, 255))});
         stream.push_back(16'h0000);
         load_stream();
         run_dec(0, t % 2, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
